// File: rtl/svpwm_dwell_time.sv
`default_nettype none
// ============================================================================
// Module   : svpwm_dwell_time
// Purpose  : Space-vector PWM dwell-time calculator. A rising edge on
//            synchr_clk starts one pass that computes the active-vector
//            dwell times T1/T2 from a sine table and the modulation
//            amplitude, derives the zero-vector time T0, and maps them onto
//            per-phase compare values for the selected sector.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            synchr_clk          - PWM triangle sync (start on 0->1)
//            sin_t1, sin_t2      - table angles in 1/16 deg (0..960)
//            vector_amplitude    - 0..8000 maps to 0..1 (clamped)
//            number_sector       - sector 1..6, anything else is an error
//            cmp_a/b/c, t1/t2/t0 - results, held between valid pulses
//            valid, busy, sector_err - result strobe, in-progress, bad sector
// Revision : 1.0 - initial release
// ============================================================================
module svpwm_dwell_time #(
    parameter int PWM_PERIOD = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        synchr_clk,
    input  logic [9:0]  sin_t1,
    input  logic [9:0]  sin_t2,
    input  logic [15:0] vector_amplitude,
    input  logic [3:0]  number_sector,
    output logic [15:0] cmp_a,
    output logic [15:0] cmp_b,
    output logic [15:0] cmp_c,
    output logic [15:0] t1,
    output logic [15:0] t2,
    output logic [15:0] t0,
    output logic        valid,
    output logic        busy,
    output logic        sector_err
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LATCH  = 4'd1;
    localparam logic [3:0] S_MUL_P  = 4'd2;
    localparam logic [3:0] S_MUL_T1 = 4'd3;
    localparam logic [3:0] S_DIV_T1 = 4'd4;
    localparam logic [3:0] S_MUL_T2 = 4'd5;
    localparam logic [3:0] S_DIV_T2 = 4'd6;
    localparam logic [3:0] S_SUM    = 4'd7;
    localparam logic [3:0] S_CMP    = 4'd8;

    localparam logic [15:0] c_period16 = 16'(PWM_PERIOD);
    localparam logic [16:0] c_period17 = {1'b0, c_period16};
    localparam logic [12:0] c_amp_max  = 13'd8000;
    localparam logic [33:0] c_div      = 34'd8000;
    localparam logic [9:0]  c_addr_max = 10'd960;

    // The table is evaluated at elaboration time so that the ROM contents
    // (identical to sin60_table.hex) travel with the RTL:
    // ROM[i] = round(32768 * sin(i/16 deg) / sin(60 deg)).
    function automatic logic [16:0] f_sin60(input int idx);
        real x, term, acc;
        x    = idx * 3.14159265358979323846 / 2880.0;
        term = x;
        acc  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / ((2.0 * k) * (2.0 * k + 1.0));
            acc  = acc + term;
        end
        return 17'($rtoi(acc * 32768.0 / 0.86602540378443864676 + 0.5));
    endfunction

    logic [16:0] w_rom_tab [0:960];
    for (genvar gi = 0; gi <= 960; gi++) begin : g_rom
        localparam logic [16:0] c_val = f_sin60(gi);
        assign w_rom_tab[gi] = c_val;
    end

    logic [3:0]  r_state;
    logic [3:0]  w_state_next;
    logic        r_sync_q;
    logic        w_start;

    logic [12:0] r_amp;
    logic [9:0]  r_sin1;
    logic [9:0]  r_sin2;
    logic [3:0]  r_sector;
    logic [31:0] r_prod;
    logic [33:0] r_rem;
    logic [14:0] r_quot;
    logic [3:0]  r_cnt;
    logic [15:0] r_dt1, r_dt2, r_dt0;

    logic [15:0] r_cmp_a, r_cmp_b, r_cmp_c;
    logic [15:0] r_t1_out, r_t2_out, r_t0_out;
    logic        r_valid, r_busy, r_sector_err;

    logic [12:0] w_amp_c;
    logic [9:0]  w_addr;
    logic [9:0]  w_addr_c;
    logic [16:0] w_rom;
    logic [31:0] w_mul_a;
    logic [16:0] w_mul_b;
    logic [48:0] w_mul;
    logic [33:0] w_div_sh;
    logic        w_ge;
    logic [15:0] w_quot_next;
    logic [16:0] w_sum;
    logic [15:0] w_h;
    logic [15:0] w_cmp_a, w_cmp_b, w_cmp_c;
    logic        w_sector_ok;

    assign w_start  = synchr_clk & ~r_sync_q;
    assign w_amp_c  = (vector_amplitude > 16'd8000) ? c_amp_max : vector_amplitude[12:0];

    // One multiplier serves all three products: amp*PERIOD first, then
    // that product times the sine entry for T1 and for T2.
    assign w_addr   = (r_state == S_MUL_T2) ? r_sin2 : r_sin1;
    assign w_addr_c = (w_addr > c_addr_max) ? c_addr_max : w_addr;
    assign w_rom    = w_rom_tab[w_addr_c];
    assign w_mul_a  = (r_state == S_MUL_P) ? {19'd0, r_amp} : r_prod;
    assign w_mul_b  = (r_state == S_MUL_P) ? c_period17 : w_rom;
    assign w_mul    = {17'd0, w_mul_a} * {32'd0, w_mul_b};

    // Restoring division: the numerator is below 8000 * 2^16, so trying
    // 8000 << k for k = 15..0 yields the full 16-bit quotient.
    assign w_div_sh    = c_div << r_cnt;
    assign w_ge        = (r_rem >= w_div_sh);
    assign w_quot_next = {r_quot, w_ge};

    assign w_sum = {1'b0, r_dt1} + {1'b0, r_dt2};
    assign w_h   = {1'b0, r_dt0[15:1]};

    always_comb begin
        w_cmp_a     = 16'd0;
        w_cmp_b     = 16'd0;
        w_cmp_c     = 16'd0;
        w_sector_ok = 1'b1;
        case (r_sector)
            4'd1: begin w_cmp_a = r_dt1 + r_dt2 + w_h; w_cmp_b = r_dt2 + w_h;         w_cmp_c = w_h;                 end
            4'd2: begin w_cmp_a = r_dt1 + w_h;         w_cmp_b = r_dt1 + r_dt2 + w_h; w_cmp_c = w_h;                 end
            4'd3: begin w_cmp_a = w_h;                 w_cmp_b = r_dt1 + r_dt2 + w_h; w_cmp_c = r_dt2 + w_h;         end
            4'd4: begin w_cmp_a = w_h;                 w_cmp_b = r_dt1 + w_h;         w_cmp_c = r_dt1 + r_dt2 + w_h; end
            4'd5: begin w_cmp_a = r_dt2 + w_h;         w_cmp_b = w_h;                 w_cmp_c = r_dt1 + r_dt2 + w_h; end
            4'd6: begin w_cmp_a = r_dt1 + r_dt2 + w_h; w_cmp_b = w_h;                 w_cmp_c = r_dt1 + w_h;         end
            default: w_sector_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_next = S_LATCH;
            S_LATCH:  w_state_next = S_MUL_P;
            S_MUL_P:  w_state_next = S_MUL_T1;
            S_MUL_T1: w_state_next = S_DIV_T1;
            S_DIV_T1: if (r_cnt == 4'd0) w_state_next = S_MUL_T2;
            S_MUL_T2: w_state_next = S_DIV_T2;
            S_DIV_T2: if (r_cnt == 4'd0) w_state_next = S_SUM;
            S_SUM:    w_state_next = S_CMP;
            S_CMP:    w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q     <= 1'b0;
            r_amp        <= '0;
            r_sin1       <= '0;
            r_sin2       <= '0;
            r_sector     <= '0;
            r_prod       <= '0;
            r_rem        <= '0;
            r_quot       <= '0;
            r_cnt        <= '0;
            r_dt1        <= '0;
            r_dt2        <= '0;
            r_dt0        <= '0;
            r_cmp_a      <= '0;
            r_cmp_b      <= '0;
            r_cmp_c      <= '0;
            r_t1_out     <= '0;
            r_t2_out     <= '0;
            r_t0_out     <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_sector_err <= 1'b0;
        end else begin
            r_sync_q     <= synchr_clk;
            r_valid      <= 1'b0;
            r_sector_err <= 1'b0;
            r_busy       <= (w_state_next != S_IDLE);
            case (r_state)
                S_LATCH: begin
                    r_amp    <= w_amp_c;
                    r_sin1   <= sin_t1;
                    r_sin2   <= sin_t2;
                    r_sector <= number_sector;
                end
                S_MUL_P: r_prod <= w_mul[31:0];
                S_MUL_T1, S_MUL_T2: begin
                    // Dropping the low 15 bits removes the 2^15 table scale.
                    r_rem  <= w_mul[48:15];
                    r_quot <= '0;
                    r_cnt  <= 4'd15;
                end
                S_DIV_T1: begin
                    if (w_ge) r_rem <= r_rem - w_div_sh;
                    r_quot <= w_quot_next[14:0];
                    r_cnt  <= r_cnt - 4'd1;
                    if (r_cnt == 4'd0) r_dt1 <= w_quot_next;
                end
                S_DIV_T2: begin
                    if (w_ge) r_rem <= r_rem - w_div_sh;
                    r_quot <= w_quot_next[14:0];
                    r_cnt  <= r_cnt - 4'd1;
                    if (r_cnt == 4'd0) r_dt2 <= w_quot_next;
                end
                S_SUM: begin
                    // T1 never exceeds the period, so trimming T2 is enough.
                    if (w_sum > c_period17) begin
                        r_dt2 <= c_period16 - r_dt1;
                        r_dt0 <= 16'd0;
                    end else begin
                        r_dt0 <= c_period16 - r_dt1 - r_dt2;
                    end
                end
                S_CMP: begin
                    if (w_sector_ok) begin
                        r_cmp_a  <= w_cmp_a;
                        r_cmp_b  <= w_cmp_b;
                        r_cmp_c  <= w_cmp_c;
                        r_t1_out <= r_dt1;
                        r_t2_out <= r_dt2;
                        r_t0_out <= r_dt0;
                        r_valid  <= 1'b1;
                    end else begin
                        r_sector_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmp_a      = r_cmp_a;
    assign cmp_b      = r_cmp_b;
    assign cmp_c      = r_cmp_c;
    assign t1         = r_t1_out;
    assign t2         = r_t2_out;
    assign t0         = r_t0_out;
    assign valid      = r_valid;
    assign busy       = r_busy;
    assign sector_err = r_sector_err;

endmodule
`default_nettype wire

// File: tb/tb_svpwm_dwell_time.sv
`default_nettype none
// ============================================================================
// Module   : tb_svpwm_dwell_time
// Purpose  : Self-checking bench for svpwm_dwell_time. Directed corner cases
//            plus randomized operations, compared against an arithmetic
//            reference model of the dwell-time and sector mapping rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_svpwm_dwell_time;

    localparam int  c_period = 2500;
    localparam real c_pi     = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic        synchr_clk;
    logic [9:0]  sin_t1, sin_t2;
    logic [15:0] vector_amplitude;
    logic [3:0]  number_sector;
    logic [15:0] cmp_a, cmp_b, cmp_c, t1, t2, t0;
    logic        valid, busy, sector_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Outputs the DUT is expected to be holding right now.
    longint e_a = 0, e_b = 0, e_c = 0, e_t1 = 0, e_t2 = 0, e_t0 = 0;
    // Model result for the operation in flight.
    longint m_a, m_b, m_c, m_t1, m_t2, m_t0;
    bit     m_good;

    always #5 clk = ~clk;

    svpwm_dwell_time #(.PWM_PERIOD(c_period)) dut (
        .clk              (clk),
        .rst              (rst),
        .synchr_clk       (synchr_clk),
        .sin_t1           (sin_t1),
        .sin_t2           (sin_t2),
        .vector_amplitude (vector_amplitude),
        .number_sector    (number_sector),
        .cmp_a            (cmp_a),
        .cmp_b            (cmp_b),
        .cmp_c            (cmp_c),
        .t1               (t1),
        .t2               (t2),
        .t0               (t0),
        .valid            (valid),
        .busy             (busy),
        .sector_err       (sector_err)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint rom_ref(input int i);
        int  j;
        real r;
        j = (i > 960) ? 960 : i;
        r = 32768.0 * $sin(j * c_pi / 2880.0) / $sin(c_pi / 3.0);
        return longint'($floor(r + 0.5));
    endfunction

    task automatic model(input int amp, input int sec, input int s1, input int s2);
        longint a, x1, x2, x0, h;
        a  = (amp > 8000) ? 8000 : amp;
        x1 = ((a * c_period * rom_ref(s1)) / 32768) / 8000;
        x2 = ((a * c_period * rom_ref(s2)) / 32768) / 8000;
        if (x1 + x2 > c_period) begin
            x2 = c_period - x1;
            x0 = 0;
        end else begin
            x0 = c_period - x1 - x2;
        end
        h      = x0 / 2;
        m_t1   = x1; m_t2 = x2; m_t0 = x0;
        m_good = 1'b1;
        case (sec)
            1: begin m_a = x1 + x2 + h; m_b = x2 + h;      m_c = h;           end
            2: begin m_a = x1 + h;      m_b = x1 + x2 + h; m_c = h;           end
            3: begin m_a = h;           m_b = x1 + x2 + h; m_c = x2 + h;      end
            4: begin m_a = h;           m_b = x1 + h;      m_c = x1 + x2 + h; end
            5: begin m_a = x2 + h;      m_b = h;           m_c = x1 + x2 + h; end
            6: begin m_a = x1 + x2 + h; m_b = h;           m_c = x1 + h;      end
            default: m_good = 1'b0;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".cmp_a"}, cmp_a, e_a);
        check_val({tag, ".cmp_b"}, cmp_b, e_b);
        check_val({tag, ".cmp_c"}, cmp_c, e_c);
        check_val({tag, ".t1"},    t1,    e_t1);
        check_val({tag, ".t2"},    t2,    e_t2);
        check_val({tag, ".t0"},    t0,    e_t0);
    endtask

    // One complete operation: start edge, then watch 60 cycles for exactly
    // one strobe at cycle 39. Optional input scrambling after the latch and
    // a second sync edge while busy.
    task automatic run_op(input int amp, input int sec, input int s1, input int s2,
                          input bit scramble, input bit extra_start);
        int v_cnt, e_cnt, v_cyc, e_cyc;
        v_cnt = 0; e_cnt = 0; v_cyc = -1; e_cyc = -1;
        model(amp, sec, s1, s2);
        @(negedge clk);
        vector_amplitude = 16'(amp);
        number_sector    = 4'(sec);
        sin_t1           = 10'(s1);
        sin_t2           = 10'(s2);
        synchr_clk       = 1'b1;
        @(negedge clk);
        synchr_clk = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (n == 1)  check_val("busy_start", busy, 1);
            if (n == 5 && scramble) begin
                vector_amplitude = 16'($urandom);
                number_sector    = 4'($urandom);
                sin_t1           = 10'($urandom);
                sin_t2           = 10'($urandom);
            end
            if (extra_start && n == 10) synchr_clk = 1'b1;
            if (extra_start && n == 12) synchr_clk = 1'b0;
            if (n == 20) check_outputs("hold");
            if (n == 38) check_val("busy_last", busy, 1);
            if (n == 39) check_val("busy_done", busy, 0);
            if (valid) begin v_cnt++; if (v_cyc < 0) v_cyc = n; end
            if (sector_err) begin e_cnt++; if (e_cyc < 0) e_cyc = n; end
            @(negedge clk);
        end
        check_val("valid_count", v_cnt, m_good ? 1 : 0);
        check_val("err_count",   e_cnt, m_good ? 0 : 1);
        if (m_good) check_val("valid_cycle", v_cyc, 39);
        else        check_val("err_cycle",   e_cyc, 39);
        if (m_good) begin
            e_a = m_a; e_b = m_b; e_c = m_c;
            e_t1 = m_t1; e_t2 = m_t2; e_t0 = m_t0;
        end
        check_outputs("result");
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (valid || sector_err || busy) hits++;
        end
        check_val(tag, hits, 0);
    endtask

    initial begin
        rst = 1'b1; synchr_clk = 1'b0;
        sin_t1 = '0; sin_t2 = '0; vector_amplitude = '0; number_sector = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_outputs("reset");
        check_val("reset.valid", valid, 0);
        check_val("reset.busy",  busy, 0);
        check_val("reset.err",   sector_err, 0);

        // Full-scale single vector.
        run_op(8000, 1, 960, 0, 1'b0, 1'b0);
        check_val("dir1.t1", t1, 2500);
        check_val("dir1.cmp_a", cmp_a, 2500);
        // Half amplitude, 30 degrees, sector 2.
        run_op(4000, 2, 480, 480, 1'b1, 1'b0);
        check_val("dir2.t1", t1, 721);
        check_val("dir2.cmp_b", cmp_b, 1971);
        check_val("dir2.cmp_c", cmp_c, 529);
        // Zero amplitude.
        run_op(0, 4, 300, 700, 1'b0, 1'b0);
        check_val("dir3.cmp_a", cmp_a, 1250);
        // Clamped amplitude with saturation.
        run_op(9000, 1, 480, 480, 1'b0, 1'b0);
        check_val("dir4.t2", t2, 1057);
        check_val("dir4.t0", t0, 0);
        // Invalid sector keeps the previous results.
        run_op(5000, 0, 200, 300, 1'b0, 1'b0);
        check_val("dir5.cmp_b", cmp_b, 1057);
        // Sync edge while busy is dropped.
        run_op(6000, 3, 100, 800, 1'b0, 1'b1);
        expect_quiet("no_second_result", 30);

        // Reset in the middle of the first division, after a busy-time edge.
        @(negedge clk);
        vector_amplitude = 16'd7000; number_sector = 4'd5;
        sin_t1 = 10'd600; sin_t2 = 10'd200; synchr_clk = 1'b1;
        @(negedge clk);
        synchr_clk = 1'b0;
        for (int n = 1; n < 10; n++) begin
            if (n == 4) synchr_clk = 1'b1;
            if (n == 6) synchr_clk = 1'b0;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e_a = 0; e_b = 0; e_c = 0; e_t1 = 0; e_t2 = 0; e_t0 = 0;
        check_outputs("abort");
        expect_quiet("abort_quiet", 60);

        // Reset coinciding with a start edge.
        rst = 1'b1; synchr_clk = 1'b1;
        @(negedge clk);
        rst = 1'b0; synchr_clk = 1'b0;
        expect_quiet("rst_vs_start", 50);

        // Randomized operations.
        for (int k = 0; k < 40; k++) begin
            int amp, sec;
            amp = ($urandom_range(0, 9) == 0) ? 65535 : int'($urandom_range(0, 9000));
            sec = ($urandom_range(0, 4) == 0) ? int'($urandom_range(7, 15)) * int'($urandom_range(0, 1))
                                              : int'($urandom_range(1, 6));
            run_op(amp, sec, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                   1'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
